// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for the iterative AES-128 encryption datapath.
// Converts a load request into init / round / output-capture strobes for the
// state and round-key registers, and tracks round number, Rcon and completion.
//
// Optional feature macro: AES_CTRL_LOAD_QUEUE_EN
//   defined   - a start while busy is remembered in a 1-deep pending flag and
//               launches the next block right after one DONE cycle.
//   undefined - a start while busy is ignored.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   load        start request (level; a sampled rising edge starts a block)
//   state_ld    capture plaintext^key into the state register
//   key_ld      capture cipher key into the round-key register
//   round_en    state register takes one round result
//   key_en      round-key register takes next expanded key
//   last_round  final round, datapath bypasses MixColumns
//   round[3:0]  current round number, 1..NR while running
//   rcon[7:0]   Rcon for key expansion of current round
//   out_ld      capture ciphertext into the output register
//   busy        high from INIT through FINAL
//   done        result valid, held while in DONE
module aes_round_ctrl #(
    parameter int unsigned NR        = 10,
    parameter logic [7:0]  RCON_INIT = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    output logic       state_ld,
    output logic       key_ld,
    output logic       round_en,
    output logic       key_en,
    output logic       last_round,
    output logic [3:0] round,
    output logic [7:0] rcon,
    output logic       out_ld,
    output logic       busy,
    output logic       done
);

    localparam int unsigned RND_W = 4;
    localparam int unsigned RCON_W = 8;
    localparam logic [RND_W-1:0] NR_R = RND_W'(NR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                load_q, load_d;
    logic [RND_W-1:0]    round_q, round_d;
    logic [RCON_W-1:0]   rcon_q, rcon_d;
    logic                start_c;
    logic                in_flight_c;
`ifdef AES_CTRL_LOAD_QUEUE_EN
    logic                pending_q, pending_d;
`endif

    // GF(2^8) multiply by x, used to step Rcon between rounds
    function automatic logic [RCON_W-1:0] xtime(input logic [RCON_W-1:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

    assign start_c     = load & ~load_q;
    assign in_flight_c = (state_q == S_INIT) || (state_q == S_ROUND) || (state_q == S_FINAL);

    // State and datapath-control registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            load_q    <= 1'b0;
            round_q   <= '0;
            rcon_q    <= '0;
`ifdef AES_CTRL_LOAD_QUEUE_EN
            pending_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            round_q   <= round_d;
            rcon_q    <= rcon_d;
`ifdef AES_CTRL_LOAD_QUEUE_EN
            pending_q <= pending_d;
`endif
        end
    end

    // Next-state, round counter and Rcon sequencing
    always_comb begin
        state_d   = state_q;
        load_d    = load;
        round_d   = round_q;
        rcon_d    = rcon_q;
`ifdef AES_CTRL_LOAD_QUEUE_EN
        pending_d = pending_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_c) state_d = S_INIT;
            end
            S_INIT: begin
                round_d = RND_W'(1);
                rcon_d  = RCON_INIT;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (round_q == NR_R) begin
                    state_d = S_FINAL;
                end else begin
                    round_d = round_q + RND_W'(1);
                    rcon_d  = xtime(rcon_q);
                end
            end
            S_FINAL: begin
                state_d = S_DONE;
            end
            S_DONE: begin
`ifdef AES_CTRL_LOAD_QUEUE_EN
                // A queued request launches after exactly one DONE cycle
                if (start_c || pending_q) begin
                    state_d   = S_INIT;
                    pending_d = 1'b0;
                end
`else
                if (start_c) state_d = S_INIT;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef AES_CTRL_LOAD_QUEUE_EN
        // Only one request is remembered; later ones while pending are dropped
        if (start_c && in_flight_c) pending_d = 1'b1;
`endif
    end

    // Moore strobes decoded from the current state
    always_comb begin
        state_ld   = 1'b0;
        key_ld     = 1'b0;
        round_en   = 1'b0;
        key_en     = 1'b0;
        last_round = 1'b0;
        out_ld     = 1'b0;
        busy       = in_flight_c;
        done       = 1'b0;
        unique case (state_q)
            S_INIT: begin
                state_ld = 1'b1;
                key_ld   = 1'b1;
            end
            S_ROUND: begin
                round_en   = 1'b1;
                key_en     = 1'b1;
                last_round = (round_q == NR_R);
            end
            S_FINAL: begin
                out_ld = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign round = round_q;
    assign rcon  = rcon_q;

endmodule
